// File: rtl/aes_stream_arbiter.sv
// Two-requester packet arbiter in front of a single AES stream core; an ID FIFO
// steers results back in grant order. Optional stall watchdog: AES_ARB_WATCHDOG_EN.
module aes_stream_arbiter #(
  parameter int DATA_W      = 128,
  parameter int ID_DEPTH    = 4,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [1:0][DATA_W-1:0] s_tdata,
  input  logic [1:0]             s_tvalid,
  input  logic [1:0]             s_tlast,
  output logic [1:0]             s_tready,
  output logic [DATA_W-1:0]      core_in_tdata,
  output logic                   core_in_tvalid,
  output logic                   core_in_tlast,
  input  logic                   core_in_tready,
  input  logic [DATA_W-1:0]      core_out_tdata,
  input  logic                   core_out_tvalid,
  input  logic                   core_out_tlast,
  output logic                   core_out_tready,
  output logic [1:0][DATA_W-1:0] m_tdata,
  output logic [1:0]             m_tvalid,
  output logic [1:0]             m_tlast,
  input  logic [1:0]             m_tready,
  output logic [1:0]             grant,
  output logic                   stall
);

  localparam int PW = $clog2(ID_DEPTH);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t              state_q, state_d;
  logic                last_served_q;
  logic [ID_DEPTH-1:0] id_mem;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [PW:0]         count;
  logic                fifo_full, fifo_empty;
  logic                push, push_id, pop, sel, head;

  assign fifo_full  = (count == (PW+1)'(ID_DEPTH));
  assign fifo_empty = (count == '0);

  // Input side: a packet owns the core input until its tlast beat is accepted
  always_comb begin
    state_d        = state_q;
    push           = 1'b0;
    push_id        = 1'b0;
    sel            = 1'b0;
    grant          = '0;
    s_tready       = '0;
    core_in_tdata  = '0;
    core_in_tvalid = 1'b0;
    core_in_tlast  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_full && |s_tvalid) begin
          push    = 1'b1;
          push_id = (&s_tvalid) ? ~last_served_q : s_tvalid[1];
          state_d = push_id ? GNT1 : GNT0;
        end
      end
      GNT0, GNT1: begin
        sel            = (state_q == GNT1);
        grant[sel]     = 1'b1;
        core_in_tdata  = s_tdata[sel];
        core_in_tvalid = s_tvalid[sel];
        core_in_tlast  = s_tlast[sel];
        s_tready[sel]  = core_in_tready;
        if (core_in_tvalid && core_in_tready && core_in_tlast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output side: results belong to the oldest outstanding grant
  always_comb begin
    head            = id_mem[rd_ptr];
    m_tdata         = '0;
    m_tvalid        = '0;
    m_tlast         = '0;
    core_out_tready = 1'b0;
    if (!fifo_empty) begin
      m_tdata[head]   = core_out_tdata;
      m_tvalid[head]  = core_out_tvalid;
      m_tlast[head]   = core_out_tlast;
      core_out_tready = m_tready[head];
    end
  end

  assign pop = core_out_tvalid & core_out_tready & core_out_tlast;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q       <= IDLE;
      last_served_q <= 1'b1;
      id_mem        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        id_mem[wr_ptr] <= push_id;
        wr_ptr         <= wr_ptr + 1'b1;
        last_served_q  <= push_id;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef AES_ARB_WATCHDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);

  logic [CW-1:0] wdog_cnt;
  logic          wdog_hit, any_hs;

  assign wdog_hit = (core_in_tvalid & ~core_in_tready) | (|(m_tvalid & ~m_tready)) |
                    (~fifo_empty & ~core_out_tvalid);
  assign any_hs   = (core_in_tvalid & core_in_tready) | (core_out_tvalid & core_out_tready);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)                                   wdog_cnt <= '0;
    else if (any_hs || !wdog_hit)                    wdog_cnt <= '0;
    else if (wdog_cnt != CW'(WDOG_CYCLES))           wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign stall = (wdog_cnt >= CW'(WDOG_CYCLES));
`else
  assign stall = 1'b0;
`endif

endmodule
